// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator core: opcode values,
// flag bit positions and the handshake FSM state encoding.
package calc_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_DIV  = 3'd6;
  localparam logic [2:0] OP_SLTU = 3'd7;

  localparam int F_ZERO  = 0;
  localparam int F_CARRY = 1;
  localparam int F_OVF   = 2;
  localparam int F_ERR   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative multiply/divide engine. Loads operands on start, then performs
// one shift-add (MUL) or restoring-subtract (DIV) step per cycle for WIDTH
// cycles. done is high during the final step; hi/lo carry the value that the
// current step produces, so on done they hold the finished result.
module calc_iter_unit #(
  parameter int WIDTH  = 8,
  parameter int DIV_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_reg;
  logic             div_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] b_reg;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;
  logic [WIDTH-1:0] div_hi_next;
  logic [WIDTH-1:0] div_lo_next;
  logic             div_sel;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // Shift-add multiply: lo holds the multiplier, consumed LSB first, while
  // the partial product grows into hi and shifts down into lo.
  assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};

  // Restoring divide: hi is the partial remainder, lo shifts the dividend
  // out at the top and the quotient bits in at the bottom.
  generate
    if (DIV_EN != 0) begin : g_div
      logic [WIDTH:0] div_shift;
      logic [WIDTH:0] div_diff;
      assign div_shift   = {hi_reg, lo_reg[WIDTH-1]};
      assign div_diff    = div_shift - {1'b0, b_reg};
      assign div_hi_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      assign div_lo_next = {lo_reg[WIDTH-2:0], ~div_diff[WIDTH]};
      assign div_sel     = div_reg;
    end else begin : g_nodiv
      assign div_hi_next = hi_reg;
      assign div_lo_next = lo_reg;
      assign div_sel     = 1'b0;
    end
  endgenerate

  assign step_hi = div_sel ? div_hi_next : mul_hi_next;
  assign step_lo = div_sel ? div_lo_next : mul_lo_next;

  assign done = busy_reg && (cnt_reg == CW'(1));
  assign hi   = step_hi;
  assign lo   = step_lo;

  // Operand load on start, then one iteration per cycle until the count expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= 1'b0;
      div_reg  <= 1'b0;
      cnt_reg  <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      b_reg    <= '0;
    end else if (start) begin
      busy_reg <= 1'b1;
      div_reg  <= is_div;
      cnt_reg  <= CW'(WIDTH);
      hi_reg   <= '0;
      lo_reg   <= a;
      b_reg    <= b;
    end else if (busy_reg) begin
      hi_reg  <= step_hi;
      lo_reg  <= step_lo;
      cnt_reg <= cnt_reg - CW'(1);
      if (cnt_reg == CW'(1)) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_seq_core.sv
// Multi-cycle calculator core with valid/ready on both sides. Single-cycle
// ALU ops go straight to HOLD; MUL and non-zero DIV run through the iterative
// unit first. Results and flags are held until the consumer accepts them.
module calc_seq_core
  import calc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIV_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] acc
);

  localparam int MSB = WIDTH - 1;

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] result_lo_reg;
  logic [WIDTH-1:0] result_hi_reg;
  logic [3:0]       flags_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             op_mul_reg;

  logic [WIDTH-1:0] opa;
  logic             accept;
  logic             div_err;
  logic             goes_iter;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] alu_lo;
  logic [WIDTH-1:0] alu_hi;
  logic [3:0]       alu_flags;
  logic [3:0]       iter_flags;

  assign opa        = acc_sel ? acc_reg : a;
  assign accept     = in_valid && (state_reg == ST_IDLE);
  assign div_err    = (op == OP_DIV) && ((b == '0) || (DIV_EN == 0));
  assign goes_iter  = (op == OP_MUL) || ((op == OP_DIV) && !div_err);
  assign iter_start = accept && goes_iter;

  assign add_full = {1'b0, opa} + {1'b0, b};
  assign sub_full = {1'b0, opa} - {1'b0, b};

  calc_iter_unit #(
    .WIDTH (WIDTH),
    .DIV_EN(DIV_EN)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (iter_start),
    .is_div(op == OP_DIV),
    .a     (opa),
    .b     (b),
    .done  (iter_done),
    .hi    (iter_hi),
    .lo    (iter_lo)
  );

  // Single-cycle result and flags for everything that skips the iterative unit,
  // including the divide-error response.
  always_comb begin
    alu_lo    = '0;
    alu_hi    = '0;
    alu_flags = '0;
    case (op)
      OP_ADD: begin
        alu_lo             = add_full[WIDTH-1:0];
        alu_flags[F_CARRY] = add_full[WIDTH];
        alu_flags[F_OVF]   = (opa[MSB] == b[MSB]) && (add_full[MSB] != opa[MSB]);
      end
      OP_SUB: begin
        alu_lo             = sub_full[WIDTH-1:0];
        alu_flags[F_CARRY] = sub_full[WIDTH];
        alu_flags[F_OVF]   = (opa[MSB] != b[MSB]) && (sub_full[MSB] != opa[MSB]);
      end
      OP_AND:  alu_lo = opa & b;
      OP_OR:   alu_lo = opa | b;
      OP_XOR:  alu_lo = opa ^ b;
      OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, (opa < b)};
      OP_DIV: begin
        alu_lo           = '1;
        alu_hi           = opa;
        alu_flags[F_ERR] = 1'b1;
      end
      default: alu_lo = '0;
    endcase
    alu_flags[F_ZERO] = (alu_lo == '0);
  end

  // Flags for a finished MUL/DIV; only MUL can overflow into the high half.
  always_comb begin
    iter_flags         = '0;
    iter_flags[F_OVF]  = op_mul_reg && (iter_hi != '0);
    iter_flags[F_ZERO] = (iter_lo == '0);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = goes_iter ? ST_ITER : ST_HOLD;
        end
      end
      ST_ITER: begin
        if (iter_done) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Result, flag and accumulator registers, written only on entry to HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_lo_reg <= '0;
      result_hi_reg <= '0;
      flags_reg     <= '0;
      acc_reg       <= '0;
      op_mul_reg    <= 1'b0;
    end else begin
      if (accept) begin
        op_mul_reg <= (op == OP_MUL);
      end
      if (accept && !goes_iter) begin
        result_lo_reg <= alu_lo;
        result_hi_reg <= alu_hi;
        flags_reg     <= alu_flags;
        if (!alu_flags[F_ERR]) begin
          acc_reg <= alu_lo;
        end
      end else if ((state_reg == ST_ITER) && iter_done) begin
        result_lo_reg <= iter_lo;
        result_hi_reg <= iter_hi;
        flags_reg     <= iter_flags;
        acc_reg       <= iter_lo;
      end
    end
  end

  assign result_lo = result_lo_reg;
  assign result_hi = result_hi_reg;
  assign flags     = flags_reg;
  assign acc       = acc_reg;

endmodule
